// File: rtl/pong_pkg.sv
// Shared definitions for the paddle ADC sequencer.
// Contents:
//   seq_state_t    - sequencer FSM state encoding
//   SCREEN_H/PAD_H - screen geometry; PAD_Y_MAX is the largest legal paddle top Y
//   XADC_CHx_ADDR  - default DRP status-register addresses of the two paddle input channels
//   code_to_pos    - 12-bit ADC code to screen position, (code * pad_max) >> 12
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_UPDATE
  } seq_state_t;

  localparam int unsigned SCREEN_H  = 600;
  localparam int unsigned PAD_H     = 80;
  localparam int unsigned PAD_Y_MAX = SCREEN_H - PAD_H;

  localparam logic [6:0] XADC_CH0_ADDR = 7'h16;
  localparam logic [6:0] XADC_CH1_ADDR = 7'h1E;

  // 12x10 unsigned multiply; the 22-bit product cannot overflow for pad_max < 1024.
  function automatic logic [9:0] code_to_pos(input logic [11:0] code,
                                             input logic [9:0]  pad_max);
    logic [21:0] prod;
    prod = 22'(code) * 22'(pad_max);
    return 10'(prod >> 12);
  endfunction

endpackage

// File: rtl/pad_filter.sv
// One paddle channel: ADC code -> position, first-sample seeding, first-order
// IIR smoothing in the position domain and clamp to 0..PAD_MAX.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (avg -> PAD_MAX/2, unseeded)
//   i_code  [11:0] : latest ADC code for this channel
//   i_load         : one-cycle strobe to take a filter step
//   i_stale        : the code is not fresh this frame; hold avg
//   o_avg   [9:0]  : filtered paddle Y
module pad_filter
  import pong_pkg::*;
#(
  parameter int unsigned PAD_MAX  = PAD_Y_MAX,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_code,
  input  logic        i_load,
  input  logic        i_stale,
  output logic [9:0]  o_avg
);

  localparam logic [9:0] PMAX = 10'(PAD_MAX);
  localparam logic [9:0] PMID = 10'(PAD_MAX / 2);

  logic [9:0]  r_avg;
  logic        r_seeded;
  logic [9:0]  w_pos;
  logic [9:0]  w_next;
  logic [10:0] w_diff;
  logic [10:0] w_step;
  logic [11:0] w_sum;

  always_comb begin
    w_pos  = code_to_pos(i_code, PMAX);
    // pos and avg both fit in 10 bits, so an 11-bit two's complement difference is exact.
    w_diff = {1'b0, w_pos} - {1'b0, r_avg};
    w_step = 11'($signed(w_diff) >>> AVG_LOG2);
    w_sum  = {w_step[10], w_step} + {2'b00, r_avg};
    if (w_sum[11]) begin
      w_next = '0;
    end else if (w_sum > {2'b00, PMAX}) begin
      w_next = PMAX;
    end else begin
      w_next = w_sum[9:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_avg    <= PMID;
      r_seeded <= 1'b0;
    end else if (i_load && !i_stale) begin
      if (!r_seeded) begin
        r_avg    <= w_pos;
        r_seeded <= 1'b1;
      end else begin
        r_avg <= w_next;
      end
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/paddle_adc_sequencer.sv
// Frame-paced XADC DRP reader for the two paddle knobs. Each frame strobe
// reads channel 0 then channel 1 over the DRP (den/drdy with timeout), then
// steps both pad_filter instances and pulses o_pad_valid.
// Ports:
//   i_clk, i_rst_n          : pixel clock, async active-low reset
//   i_frame                 : start-of-frame strobe
//   i_clr_err               : clears the sticky error flags (a same-cycle set wins)
//   o_drp_den, o_drp_daddr  : DRP request
//   i_drp_drdy, i_drp_do    : DRP response, ADC code in i_drp_do[15:4]
//   o_pad0, o_pad1          : filtered paddle Y positions
//   o_pad_valid             : one-cycle pulse when the pads update
//   o_busy                  : sequence in progress
//   o_timeout_err           : sticky, a drdy was missed
//   o_overrun_err           : sticky, a frame arrived while busy
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a frame strobe
// ST_REQ0   | den pulse for channel 0
// ST_WAIT0  | waiting for channel 0 drdy or timeout
// ST_REQ1   | den pulse for channel 1
// ST_WAIT1  | waiting for channel 1 drdy or timeout
// ST_UPDATE | step filters; pads valid next cycle
module paddle_adc_sequencer
  import pong_pkg::*;
#(
  parameter logic [6:0]  CH0_ADDR = XADC_CH0_ADDR,
  parameter logic [6:0]  CH1_ADDR = XADC_CH1_ADDR,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned PAD_MAX  = PAD_Y_MAX
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic        i_clr_err,
  output logic        o_drp_den,
  output logic [6:0]  o_drp_daddr,
  input  logic        i_drp_drdy,
  input  logic [15:0] i_drp_do,
  output logic [9:0]  o_pad0,
  output logic [9:0]  o_pad1,
  output logic        o_pad_valid,
  output logic        o_busy,
  output logic        o_timeout_err,
  output logic        o_overrun_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [11:0]   r_code0;
  logic [11:0]   r_code1;
  logic [11:0]   w_code;
  logic          r_stale0;
  logic          r_stale1;
  logic          r_pad_valid;
  logic          r_timeout_err;
  logic          r_overrun_err;
  logic          w_tc;
  logic          w_cap0;
  logic          w_cap1;
  logic          w_to0;
  logic          w_to1;
  logic          w_load;

  assign w_code = 12'(i_drp_do >> 4);
  assign w_tc   = (r_wait_cnt == CW'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_drp_den   = 1'b0;
    o_drp_daddr = CH0_ADDR;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    w_to0       = 1'b0;
    w_to1       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame) w_state_nxt = ST_REQ0;
      end
      ST_REQ0: begin
        o_drp_den   = 1'b1;
        w_state_nxt = ST_WAIT0;
      end
      ST_WAIT0: begin
        // data takes priority over a timeout reached in the same cycle
        if (i_drp_drdy) begin
          w_cap0      = 1'b1;
          w_state_nxt = ST_REQ1;
        end else if (w_tc) begin
          w_to0       = 1'b1;
          w_state_nxt = ST_REQ1;
        end
      end
      ST_REQ1: begin
        o_drp_den   = 1'b1;
        o_drp_daddr = CH1_ADDR;
        w_state_nxt = ST_WAIT1;
      end
      ST_WAIT1: begin
        o_drp_daddr = CH1_ADDR;
        if (i_drp_drdy) begin
          w_cap1      = 1'b1;
          w_state_nxt = ST_UPDATE;
        end else if (w_tc) begin
          w_to1       = 1'b1;
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        o_drp_daddr = CH1_ADDR;
        w_load      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The wait counter reads 1 in the first WAIT cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_REQ0 || r_state == ST_REQ1) begin
      r_wait_cnt <= CW'(1);
    end else if (r_state == ST_WAIT0 || r_state == ST_WAIT1) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_code0     <= '0;
      r_code1     <= '0;
      r_stale0    <= 1'b0;
      r_stale1    <= 1'b0;
      r_pad_valid <= 1'b0;
    end else begin
      if (w_cap0) r_code0 <= w_code;
      if (w_cap1) r_code1 <= w_code;
      if (w_cap0 || w_to0) r_stale0 <= w_to0;
      if (w_cap1 || w_to1) r_stale1 <= w_to1;
      r_pad_valid <= w_load;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_timeout_err <= w_to0 | w_to1 | (r_timeout_err & ~i_clr_err);
      r_overrun_err <= (i_frame && r_state != ST_IDLE) | (r_overrun_err & ~i_clr_err);
    end
  end

  pad_filter #(.PAD_MAX(PAD_MAX), .AVG_LOG2(AVG_LOG2)) u_filt0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (r_code0),
    .i_load  (w_load),
    .i_stale (r_stale0),
    .o_avg   (o_pad0)
  );

  pad_filter #(.PAD_MAX(PAD_MAX), .AVG_LOG2(AVG_LOG2)) u_filt1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_code  (r_code1),
    .i_load  (w_load),
    .i_stale (r_stale1),
    .o_avg   (o_pad1)
  );

  assign o_pad_valid   = r_pad_valid;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_overrun_err = r_overrun_err;

endmodule
